// File: rtl/program_loader.sv
// Boot-time loader: frames a UART byte stream into 32-bit words for the instruction ROM write port.
// Optional trailing XOR checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        reload,
    output logic        imem_wr_en,
    output logic [7:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [8:0]        remain_q, remain_d;
    logic [7:0]        addr_q, addr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              ready_q, ready_d;
    logic              hold_q, done_q, err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif
    logic              accept;

    assign accept = rx_valid & ready_q;

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        remain_d  = remain_q;
        addr_d    = addr_q;
        tmo_d     = tmo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (accept) begin
                    remain_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    idx_d    = 2'd0;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                // remain_q reaches 0 only without the checksum: one cycle after the last strobe
                if (remain_q == 9'd0) begin
                    state_d = S_DONE;
                end else if (accept) begin
                    tmo_d  = '0;
                    word_d = {rx_data, word_q[23:8]};
                    idx_d  = idx_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ rx_data;
`endif
                    if (idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {rx_data, word_q};
                        addr_d    = addr_q + 8'd1;
                        remain_d  = remain_q - 9'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        if (remain_q == 9'd1) begin
                            state_d = S_CHECK;
                        end
`endif
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    tmo_d   = '0;
                    state_d = (rx_data == xor_q) ? S_DONE : S_ERROR;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`endif
            S_DONE, S_ERROR: begin
                if (reload) begin
                    state_d = S_IDLE;
                    addr_d  = 8'd0;
                    idx_d   = 2'd0;
                    tmo_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    xor_d   = 8'd0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                | (state_d == S_CHECK)
`endif
                | ((state_d == S_DATA) && (remain_d != 9'd0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            word_q    <= 24'd0;
            remain_q  <= 9'd0;
            addr_q    <= 8'd0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 32'd0;
            ready_q   <= 1'b0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            remain_q  <= remain_d;
            addr_q    <= addr_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            hold_q    <= (state_d != S_DONE);
            done_q    <= (state_d == S_DONE);
            err_q     <= (state_d == S_ERROR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign rx_ready   = ready_q;
    assign imem_wr_en = wr_en_q;
    assign imem_addr  = wr_addr_q;
    assign imem_wdata = wr_data_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (checksum steps follow PROGRAM_LOADER_CHECKSUM_EN).
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic        imem_wr_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  csum;
    logic [7:0]  wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] exp_words[$];
    int          base;

    program_loader #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_wr_en (imem_wr_en),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    // Write port log, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            wr_addr_log.push_back(imem_addr);
            wr_data_log.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            csum = csum ^ w[8*i +: 8];
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic finish_ok(input string tag);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(csum);
`else
        check({tag, "_done_late"}, 32'(load_done), 32'd0);
        check({tag, "_ready_last"}, 32'(rx_ready), 32'd0);
        @(negedge clk);
`endif
        check({tag, "_done"}, 32'(load_done), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_err"}, 32'(load_error), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_wr_en", 32'(imem_wr_en), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(rx_ready), 32'd1);

        // Two-word frame
        csum = 8'h00;
        send_byte(8'h02);
        send_word(32'h2022_0013);
        check("a0_wr_en", 32'(imem_wr_en), 32'd1);
        check("a0_addr", 32'(imem_addr), 32'd0);
        check("a0_data", imem_wdata, 32'h2022_0013);
        check("a0_hold", 32'(cpu_hold), 32'd1);
        send_word(32'h0800_0000);
        check("a1_wr_en", 32'(imem_wr_en), 32'd1);
        check("a1_addr", 32'(imem_addr), 32'd1);
        check("a1_data", imem_wdata, 32'h0800_0000);
        check("a_csum_val", 32'(csum), 32'h19);
        finish_ok("a");
        repeat (2) @(negedge clk);
        check("a_wr_count", 32'(wr_addr_log.size()), 32'd2);

        // rx_valid held in DONE
        rx_data = 8'h55; rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("done_ready", 32'(rx_ready), 32'd0);
        check("done_no_wr", 32'(wr_addr_log.size()), 32'd2);
        check("done_level", 32'(load_done), 32'd1);
        rx_valid = 1'b0;

        pulse_reload();
        check("reload_ready", 32'(rx_ready), 32'd1);
        check("reload_done", 32'(load_done), 32'd0);
        check("reload_hold", 32'(cpu_hold), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Bad checksum, then reload and resend
        csum = 8'h00;
        send_byte(8'h02);
        send_word(32'h2022_0013);
        send_word(32'h0800_0000);
        send_byte(8'h00);
        check("bad_err", 32'(load_error), 32'd1);
        check("bad_hold", 32'(cpu_hold), 32'd1);
        check("bad_done", 32'(load_done), 32'd0);
        pulse_reload();
        check("bad_reload_err", 32'(load_error), 32'd0);
        csum = 8'h00;
        send_byte(8'h02);
        send_word(32'h2022_0013);
        check("re0_addr", 32'(imem_addr), 32'd0);
        send_word(32'h0800_0000);
        check("re1_addr", 32'(imem_addr), 32'd1);
        finish_ok("resend");
        pulse_reload();
`endif

        // reload during DATA is ignored
        csum = 8'h00;
        send_byte(8'h01);
        csum = csum ^ 8'hAA;
        send_byte(8'hAA);
        pulse_reload();
        check("rl_data_ready", 32'(rx_ready), 32'd1);
        csum = csum ^ 8'hBB ^ 8'hCC ^ 8'hDD;
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check("rl_wr_en", 32'(imem_wr_en), 32'd1);
        check("rl_addr", 32'(imem_addr), 32'd0);
        check("rl_data", imem_wdata, 32'hDDCC_BBAA);
        finish_ok("rl");

        // Timeout after a partial word
        pulse_reload();
        repeat (2) @(negedge clk);
        base = wr_addr_log.size();
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (7) @(negedge clk);
        check("tmo_early", 32'(load_error), 32'd0);
        @(negedge clk);
        check("tmo_err", 32'(load_error), 32'd1);
        check("tmo_hold", 32'(cpu_hold), 32'd1);
        check("tmo_ready", 32'(rx_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("tmo_no_wr", 32'(wr_addr_log.size()), 32'(base));

        // Reset mid-frame, then a fresh frame
        pulse_reload();
        send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        reset = 1'b0;
        #1;
        check("mrst_ready", 32'(rx_ready), 32'd0);
        check("mrst_hold", 32'(cpu_hold), 32'd1);
        check("mrst_wr_en", 32'(imem_wr_en), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        csum = 8'h00;
        send_byte(8'h01);
        send_word(32'hD4C3_B2A1);
        check("mrst_addr", 32'(imem_addr), 32'd0);
        check("mrst_data", imem_wdata, 32'hD4C3_B2A1);
        finish_ok("mrst");

        // Full 256-word image, one byte per cycle
        pulse_reload();
        repeat (2) @(negedge clk);
        base = wr_addr_log.size();
        csum = 8'h00;
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            logic [7:0]  k;
            logic [31:0] w;
            k = 8'(i);
            w = {k ^ 8'h5A, ~k, k, k ^ 8'hC3};
            exp_words.push_back(w);
            send_word(w);
        end
        check("big_last_addr", 32'(imem_addr), 32'd255);
        finish_ok("big");
        repeat (6) @(negedge clk);
        check("big_count", 32'(wr_addr_log.size() - base), 32'd256);
        for (int i = 0; i < 256; i++) begin
            if (base + i < wr_addr_log.size()) begin
                check("big_addr", 32'(wr_addr_log[base + i]), 32'(i));
                check("big_data", wr_data_log[base + i], exp_words[i]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
